// File: rtl/icon_rx_opbuf.sv
// icon_rx_opbuf: interconnect receive endpoint with address-tagged op0/op1 buffers.
// Optional macro ICON_RX_BYPASS_EN forwards an accepted beat to a same-cycle lookup.
package icon_rx_pkg;
    localparam int EUIDX_W = 2;

    typedef struct packed {
        logic [EUIDX_W-1:0] euidx;
        logic [3:0]         uid;
        logic               spec;
    } type_exec_unit_addr;

    typedef logic [7:0] type_exec_unit_data;

    typedef struct packed {
        type_exec_unit_addr addr;
        type_exec_unit_data data;
        logic               valid;
    } type_icon_tx_channel;

    typedef struct packed {
        logic success;
    } type_icon_rx_channel;
endpackage

module icon_rx_opbuf
    import icon_rx_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int EU_IDX = 0
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_icon_opx,
    input  logic [$bits(type_icon_tx_channel)-1:0] i_icon_tx,
    output logic [$bits(type_icon_rx_channel)-1:0] o_icon_rx,
    input  logic [$bits(type_exec_unit_addr)-1:0]  i_op0_addr,
    input  logic                                  i_op0_consume,
    output logic [$bits(type_exec_unit_data)-1:0]  o_op0_data,
    output logic                                  o_op0_valid,
    input  logic [$bits(type_exec_unit_addr)-1:0]  i_op1_addr,
    input  logic                                  i_op1_consume,
    output logic [$bits(type_exec_unit_data)-1:0]  o_op1_data,
    output logic                                  o_op1_valid,
    output logic                                  o_op0_full,
    output logic                                  o_op1_full,
    output logic [$clog2(DEPTH):0]                o_op0_count,
    output logic [$clog2(DEPTH):0]                o_op1_count
);
    localparam int AW = $bits(type_exec_unit_addr);
    localparam int DW = $bits(type_exec_unit_data);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [EUIDX_W-1:0] EU = EUIDX_W'(EU_IDX);

    type_icon_tx_channel tx;
    logic                accept;

    logic [AW-1:0]    lk_addr [2];
    logic             cons    [2];
    logic             sel     [2];

    logic [DEPTH-1:0] valid_q [2];
    logic [DEPTH-1:0] valid_d [2];
    logic [AW-1:0]    addr_q  [2][DEPTH];
    logic [AW-1:0]    addr_d  [2][DEPTH];
    logic [DW-1:0]    data_q  [2][DEPTH];
    logic [DW-1:0]    data_d  [2][DEPTH];

    logic             lk_hit  [2];
    logic [IW-1:0]    lk_idx  [2];
    logic             wr_hit  [2];
    logic [IW-1:0]    wr_idx  [2];
    logic [IW-1:0]    fr_idx  [2];
    logic [CW-1:0]    cnt     [2];
    logic             full    [2];
    logic             byp     [2];
    logic             hit_v   [2];
    logic [DW-1:0]    hit_d   [2];

    assign tx         = type_icon_tx_channel'(i_icon_tx);
    assign lk_addr[0] = i_op0_addr;
    assign lk_addr[1] = i_op1_addr;
    assign cons[0]    = i_op0_consume;
    assign cons[1]    = i_op1_consume;
    assign sel[0]     = ~i_icon_opx;
    assign sel[1]     = i_icon_opx;

    // Search, free-slot pick and occupancy all come from registered state.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            lk_hit[b] = 1'b0;
            lk_idx[b] = '0;
            wr_hit[b] = 1'b0;
            wr_idx[b] = '0;
            fr_idx[b] = '0;
            cnt[b]    = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (!valid_q[b][i]) fr_idx[b] = IW'(i);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[b][i] && addr_q[b][i] == lk_addr[b]) begin
                    lk_hit[b] = 1'b1;
                    lk_idx[b] = IW'(i);
                end
                if (valid_q[b][i] && addr_q[b][i] == tx.addr) begin
                    wr_hit[b] = 1'b1;
                    wr_idx[b] = IW'(i);
                end
                cnt[b] = cnt[b] + CW'(valid_q[b][i]);
            end
            full[b] = (cnt[b] == CW'(DEPTH));
        end
    end

    always_comb begin
        accept = tx.valid && (tx.addr.euidx == EU) &&
                 (i_icon_opx ? (wr_hit[1] || !full[1])
                             : (wr_hit[0] || !full[0]));
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
`ifdef ICON_RX_BYPASS_EN
            byp[b] = accept && sel[b] && (tx.addr == lk_addr[b]);
`else
            byp[b] = 1'b0;
`endif
            hit_v[b] = lk_hit[b] || byp[b];
            if (byp[b])
                hit_d[b] = tx.data;
            else if (lk_hit[b])
                hit_d[b] = data_q[b][lk_idx[b]];
            else
                hit_d[b] = '0;
        end
    end

    // Consume is applied after the write so it wins on the same entry.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        for (int b = 0; b < 2; b++) begin
            if (accept && sel[b] && !(byp[b] && cons[b])) begin
                if (wr_hit[b]) begin
                    data_d[b][wr_idx[b]] = tx.data;
                end else begin
                    valid_d[b][fr_idx[b]] = 1'b1;
                    addr_d[b][fr_idx[b]]  = tx.addr;
                    data_d[b][fr_idx[b]]  = tx.data;
                end
            end
            if (cons[b] && lk_hit[b]) valid_d[b][lk_idx[b]] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
        end else begin
            valid_q <= valid_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign o_icon_rx   = accept;
    assign o_op0_valid = hit_v[0];
    assign o_op0_data  = hit_d[0];
    assign o_op1_valid = hit_v[1];
    assign o_op1_data  = hit_d[1];
    assign o_op0_full  = full[0];
    assign o_op1_full  = full[1];
    assign o_op0_count = cnt[0];
    assign o_op1_count = cnt[1];
endmodule

// File: tb/tb_icon_rx_opbuf.sv
// tb_icon_rx_opbuf: directed stimulus with a lookup scoreboard for icon_rx_opbuf.
// Expected lookups are queued as beats are driven and checked when looked up.
module tb_icon_rx_opbuf;
    import icon_rx_pkg::*;

    logic       clk;
    logic       rst;
    logic       opx;
    logic [15:0] tx;
    logic       rx;
    logic [6:0] a0, a1;
    logic       c0, c1;
    logic [7:0] d0, d1;
    logic       v0, v1;
    logic       f0, f1;
    logic [2:0] n0, n1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        bit         op;
        logic [6:0] addr;
        bit         v;
        logic [7:0] d;
    } sb_t;

    sb_t sb [$];

    icon_rx_opbuf #(.DEPTH(4), .EU_IDX(2)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_icon_opx   (opx),
        .i_icon_tx    (tx),
        .o_icon_rx    (rx),
        .i_op0_addr   (a0),
        .i_op0_consume(c0),
        .o_op0_data   (d0),
        .o_op0_valid  (v0),
        .i_op1_addr   (a1),
        .i_op1_consume(c1),
        .o_op1_data   (d1),
        .o_op1_valid  (v1),
        .o_op0_full   (f0),
        .o_op1_full   (f1),
        .o_op0_count  (n0),
        .o_op1_count  (n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] mk(input int eu, input int uid, input int sp);
        return {2'(eu), 4'(uid), 1'(sp)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit op, input logic [6:0] ad, input logic [7:0] dt);
        opx = op;
        tx  = {ad, dt, 1'b1};
    endtask

    task automatic idle();
        tx = '0;
        c0 = 1'b0;
        c1 = 1'b0;
    endtask

    task automatic push(input string tag, input bit op, input logic [6:0] ad,
                        input bit v, input logic [7:0] dt);
        sb_t e;
        e.tag = tag;
        e.op = op;
        e.addr = ad;
        e.v = v;
        e.d = dt;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.op) a1 = e.addr;
            else a0 = e.addr;
            #1;
            check({e.tag, "_v"}, e.op ? v1 : v0, e.v);
            check({e.tag, "_d"}, e.op ? d1 : d0, e.d);
            tick();
        end
    endtask

    initial begin
        logic [6:0] aa, bb, cc, dd;
        logic [2:0] exp_n;
        rst = 1'b1;
        opx = 1'b0;
        a0 = '0;
        a1 = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_succ", rx, 0);
        check("rst_v0", v0, 0);
        check("rst_v1", v1, 0);
        check("rst_d0", d0, 0);
        check("rst_n0", n0, 0);
        check("rst_n1", n1, 0);
        check("rst_f0", f0, 0);
        check("rst_f1", f1, 0);
        tick();

        aa = mk(2, 3, 1);
        beat(0, aa, 8'hA5);
        #1;
        check("a0_succ", rx, 1);
        tick();
        idle();
        #1;
        check("a0_n0", n0, 1);
        push("a0_op0", 0, aa, 1, 8'hA5);
        push("a0_op1", 1, aa, 0, 8'h00);
        drain();

        beat(0, mk(1, 3, 1), 8'h11);
        #1;
        check("eu_succ", rx, 0);
        tick();
        idle();
        #1;
        check("eu_n0", n0, 1);
        check("eu_n1", n1, 0);

        for (int i = 0; i < 4; i++) begin
            beat(1, mk(2, i, 0), 8'(8'h10 + i));
            #1;
            check($sformatf("fill%0d_succ", i), rx, 1);
            push($sformatf("fill%0d", i), 1, mk(2, i, 0), 1, 8'(8'h10 + i));
            tick();
        end
        idle();
        #1;
        check("fill_full", f1, 1);
        check("fill_n1", n1, 4);
        drain();

        bb = mk(2, 4, 0);
        beat(1, bb, 8'h14);
        a1 = mk(2, 0, 0);
        c1 = 1'b1;
        #1;
        check("ovf_succ", rx, 0);
        check("ovf_cons_v", v1, 1);
        tick();
        idle();
        #1;
        check("ovf_n1", n1, 3);
        check("ovf_full", f1, 0);
        beat(1, bb, 8'h14);
        #1;
        check("retry_succ", rx, 1);
        tick();
        idle();
        #1;
        check("retry_n1", n1, 4);
        check("retry_full", f1, 1);
        push("retry_b4", 1, bb, 1, 8'h14);
        push("retry_b0", 1, mk(2, 0, 0), 0, 8'h00);
        drain();

        beat(0, aa, 8'h3C);
        #1;
        check("rw_succ", rx, 1);
        tick();
        idle();
        #1;
        check("rw_n0", n0, 1);
        push("rw_look", 0, aa, 1, 8'h3C);
        drain();

        beat(0, aa, 8'h55);
        a0 = aa;
        c0 = 1'b1;
        #1;
        check("wc_succ", rx, 1);
        tick();
        idle();
        #1;
        check("wc_n0", n0, 0);
        push("wc_look", 0, aa, 0, 8'h00);
        drain();

        cc = mk(2, 5, 0);
        a0 = cc;
        beat(0, cc, 8'h77);
        #1;
        check("byp_succ", rx, 1);
`ifdef ICON_RX_BYPASS_EN
        check("byp_v0", v0, 1);
        check("byp_d0", d0, 8'h77);
`else
        check("byp_v0", v0, 0);
        check("byp_d0", d0, 8'h00);
`endif
        tick();
        idle();
        #1;
        check("byp_next_v0", v0, 1);
        check("byp_next_d0", d0, 8'h77);
        check("byp_n0", n0, 1);

        dd = mk(2, 6, 1);
        a0 = dd;
        c0 = 1'b1;
        beat(0, dd, 8'h99);
        #1;
        check("bc_succ", rx, 1);
        tick();
        idle();
        #1;
`ifdef ICON_RX_BYPASS_EN
        exp_n = 3'd1;
`else
        exp_n = 3'd2;
`endif
        check("bc_n0", n0, exp_n);

        rst = 1'b1;
        beat(1, mk(2, 9, 0), 8'hEE);
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("rst2_n0", n0, 0);
        check("rst2_n1", n1, 0);
        check("rst2_f1", f1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icon_rx_opbuf.md
Name: icon_rx_opbuf

Overview:
- Receiving endpoint of the interconnect channel at one exec unit.
- Accepts type_icon_tx_channel beats tagged with opx and returns type_icon_rx_channel.success in the same cycle.
- Stores accepted operands in two small address-tagged buffers, one for op0 and one for op1.
- Serves address lookups from the ALU operand-fetch stage, which fill op0_data/op0_valid and op1_data/op1_valid of type_alu_channel_rx.

Parameters:
- DEPTH, 4, entries per operand buffer (power of 2, minimum 2).
- EU_IDX, 0, this exec unit's euidx; beats carrying a different euidx are refused.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_icon_opx  in  1  target buffer of the beat: 0 = op0, 1 = op1
- i_icon_tx  in  $bits(type_icon_tx_channel)  {addr, data, valid}
- o_icon_rx  out  $bits(type_icon_rx_channel)  {success}
- i_op0_addr  in  $bits(type_exec_unit_addr)  op0 lookup address
- i_op0_consume  in  1  free the matching op0 entry at the clock edge
- o_op0_data  out  $bits(type_exec_unit_data)  op0 lookup data
- o_op0_valid  out  1  op0 lookup hit
- i_op1_addr, i_op1_consume, o_op1_data, o_op1_valid  same as op0, for the op1 buffer
- o_op0_full, o_op1_full  out  1  every entry of that buffer is valid
- o_op0_count, o_op1_count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- State per entry: valid bit, addr (type_exec_unit_addr), data (type_exec_unit_data).
- Reset: all valid bits cleared on the first rising edge with i_reset high. Outputs then read success=0, valid=0, data=0, full=0, count=0. Reset overrides any write or consume in the same cycle.
- Accept condition, evaluated combinationally:
  - tx.valid is high, and
  - tx.addr.euidx == EU_IDX, and
  - either the target buffer already holds addr (hit) or the target buffer is not full.
- Success: o_icon_rx.success = accept, in the same cycle. The transmitter holds the beat until it sees success. No registered ack.
- Write at the edge when accepted:
  - Hit: data is overwritten in place, count unchanged.
  - Miss: written to the lowest-index invalid entry, count+1.
- Refused beats (euidx mismatch, or full with no hit) have no state effect and success=0.
- Lookups are combinational:
  - o_opN_valid = some valid entry has addr == i_opN_addr.
  - o_opN_data = that entry's data, else 0.
  - The buffer never holds duplicate addresses, so at most one entry can match.
- Consume: at the edge with i_opN_consume=1 and o_opN_valid=1, the matching entry's valid bit is cleared. Consume on a miss does nothing.
- Full and count are computed from registered state only:
  - A slot freed by consume in cycle N is not usable until cycle N+1.
  - A beat to a full buffer in cycle N is refused even if a consume occurs in the same cycle.
- Simultaneous write-hit and consume on the same entry: consume wins; the entry is cleared and success=1 (the data is dropped).
- op0 and op1 paths are fully independent. At most one beat arrives per cycle.
- Latency: an accepted beat is visible to lookups one cycle after acceptance (default build).

Optional Feature:
- Macro: ICON_RX_BYPASS_EN.
- Defined: when an accepted beat's addr equals i_opN_addr of its target buffer in the same cycle, o_opN_valid=1 and o_opN_data=tx.data, giving a zero-cycle lookup. A consume in that cycle discards the beat: no entry is allocated, count is unchanged, success=1.
- Undefined: no forwarding; lookups see registered state only.

Test Plan:
- Reset, then idle → success=0, op0/op1 valid=0, count=0, full=0.
- EU_IDX=2. Beat {euidx=2, uid=3, spec=1, data=0xA5}, opx=0 → success=1. Next cycle, lookup of that addr on op0 → valid=1, data=0xA5, op0_count=1; op1 lookup of the same addr → valid=0.
- Beat with euidx=1 → success=0, counts unchanged.
- Fill op1 with 4 distinct addresses → full=1. Fifth new address → success=0. Same cycle as a consume of entry 0 → still refused. Retry next cycle → accepted into entry 0.
- Rewrite an existing op0 addr with 0x3C → success=1, count unchanged, lookup returns 0x3C. Write-hit combined with consume → entry cleared, count-1.
- With ICON_RX_BYPASS_EN: beat data=0x77 whose addr equals i_op0_addr → o_op0_valid=1, data=0x77 in the same cycle. Without the macro → valid=0 that cycle, 1 the next.
